texter_lcd_sequencer: RTL and testbench

Sequences the character LCD (HD44780-compatible, 16x2, 8-bit bus) for the single button texter. It queues the one-cycle `out_char`/`out_space`/`back_sp` events from the texter controller in a small FIFO. It runs the LCD power-up/init command sequence, then turns each queued event into timed LCD bus transactions with cursor tracking and wrap-around. It sits between the texter control/decoder and the DE-2 LCD pins, driven by the same 27 MHz clock.

---
 rtl/texter_lcd_sequencer_if.sv | 25 ++
 rtl/texter_lcd_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_texter_lcd_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/texter_lcd_sequencer_if.sv
// Request/LCD-bus bundle between the texter controller and the LCD sequencer.
// The master side raises the one-cycle requests and watches the LCD pins and
// status; the slave side is the sequencer itself.
interface texter_lcd_sequencer_if;
  logic       char_req;
  logic [7:0] char_code;
  logic       space_req;
  logic       bksp_req;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       busy;
  logic       overflow;

  modport master (
    output char_req, char_code, space_req, bksp_req,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, busy, overflow
  );

  modport slave (
    input  char_req, char_code, space_req, bksp_req,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, busy, overflow
  );
endinterface

// File: rtl/texter_lcd_sequencer.sv
// HD44780 (16x2, 8-bit) sequencer for the single-button texter.
// Queues char/space/backspace events, runs the power-up wait and init
// commands, then turns each event into an address TX plus a data TX with
// cursor tracking over the 32 visible cells (wrapping 31 -> 0).
module texter_lcd_sequencer #(
  parameter int unsigned EN_HIGH_CYC  = 12,
  parameter int unsigned CMD_WAIT_CYC = 1200,
  parameter int unsigned CLR_WAIT_CYC = 45000,
  parameter int unsigned PWRUP_CYC    = 405000,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  texter_lcd_sequencer_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {EV_CHAR, EV_SPACE, EV_BKSP} ev_kind_e;

  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] code;
  } fifo_entry_t;

  typedef enum logic [2:0] {ST_PWR, ST_INIT, ST_IDLE, ST_ADDR, ST_DATA} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_e;

  // ---------------------------------------------------------------- FIFO
  fifo_entry_t        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow_q;
  logic               push, push_ok, pop, full, empty;
  fifo_entry_t        push_entry, head;

  // ---------------------------------------------------------------- FSM
  state_e      state;
  phase_e      phase;
  logic [31:0] cnt;
  logic [31:0] wait_last;
  logic [1:0]  init_idx;
  logic [4:0]  pos;
  logic [7:0]  data_byte;
  logic [7:0]  lcd_data_q;
  logic        lcd_rs_q;
  logic        lcd_en_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;   // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;   // display on, cursor off
      2'd2:    return 8'h01;   // clear display
      default: return 8'h06;   // entry mode: increment, no shift
    endcase
  endfunction

  // Set-DDRAM-address command: line 1 starts at 0x00, line 2 at 0x40.
  function automatic logic [7:0] addr_cmd(input logic [4:0] p);
    return {1'b1, p[4], 2'b00, p[3:0]};
  endfunction

  // Request arbitration: backspace wins over char, char over space.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    push       = bus.bksp_req | bus.char_req | bus.space_req;
    push_entry = '{kind: EV_SPACE, code: 8'h20};
    if (bus.bksp_req)
      push_entry = '{kind: EV_BKSP, code: 8'h20};
    else if (bus.char_req)
      push_entry = '{kind: EV_CHAR, code: bus.char_code};
  end

  assign full    = count[FIFO_AW];
  assign empty   = (count == '0);
  assign pop     = (state == ST_IDLE) && !empty;
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; the pointers and
  // count decide which entries are valid, so reset only touches those.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // The clear command needs the long wait; everything else the short one.
  assign wait_last = (lcd_data_q == 8'h01 && !lcd_rs_q) ? CLR_WAIT_CYC - 1
                                                        : CMD_WAIT_CYC - 1;

  // Main sequencer: power-up wait, init commands, then event service.
  // Each TX is SETUP (1 cycle) -> EN (EN_HIGH_CYC) -> WAIT (per command).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PWR;
      phase      <= PH_SETUP;
      cnt        <= '0;
      init_idx   <= '0;
      pos        <= '0;
      data_byte  <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
      case (state)
        ST_PWR: begin
          if (cnt == PWRUP_CYC - 1) begin
            state      <= ST_INIT;
            phase      <= PH_SETUP;
            cnt        <= '0;
            init_idx   <= '0;
            lcd_data_q <= init_cmd(2'd0);
            lcd_rs_q   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (!empty) begin
            phase <= PH_SETUP;
            cnt   <= '0;
            if (head.kind == EV_BKSP) begin
              // Backspace at the home cell is swallowed without LCD traffic.
              if (pos != '0) begin
                pos        <= pos - 5'd1;
                state      <= ST_ADDR;
                lcd_data_q <= addr_cmd(pos - 5'd1);
                lcd_rs_q   <= 1'b0;
                data_byte  <= 8'h20;
              end
            end else begin
              // Cursor advances at pop time; 5-bit wrap gives 31 -> 0.
              pos        <= pos + 5'd1;
              state      <= ST_ADDR;
              lcd_data_q <= addr_cmd(pos);
              lcd_rs_q   <= 1'b0;
              data_byte  <= head.code;
            end
          end
        end

        ST_INIT, ST_ADDR, ST_DATA: begin
          case (phase)
            PH_SETUP: begin
              phase    <= PH_EN;
              lcd_en_q <= 1'b1;
              cnt      <= '0;
            end
            PH_EN: begin
              if (cnt == EN_HIGH_CYC - 1) begin
                phase    <= PH_WAIT;
                lcd_en_q <= 1'b0;
                cnt      <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            PH_WAIT: begin
              if (cnt == wait_last) begin
                cnt   <= '0;
                phase <= PH_SETUP;
                if (state == ST_INIT) begin
                  if (init_idx == 2'd3) begin
                    state <= ST_IDLE;
                  end else begin
                    init_idx   <= init_idx + 2'd1;
                    lcd_data_q <= init_cmd(init_idx + 2'd1);
                  end
                end else if (state == ST_ADDR) begin
                  state      <= ST_DATA;
                  lcd_data_q <= data_byte;
                  lcd_rs_q   <= 1'b1;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: phase <= PH_SETUP;
          endcase
        end

        default: state <= ST_PWR;
      endcase
    end
  end

  assign bus.lcd_data = lcd_data_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = lcd_en_q;
  assign bus.busy     = (state != ST_IDLE) || !empty;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_texter_lcd_sequencer.sv
// Directed bench for texter_lcd_sequencer with short timing parameters:
// EN=2, CMD wait=4, CLR wait=8, power-up=10, so a command TX spans 7 cycles
// and the clear TX spans 11. Outputs are sampled on the falling clock edge.
module tb_texter_lcd_sequencer;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  texter_lcd_sequencer_if bus ();

  texter_lcd_sequencer #(
    .EN_HIGH_CYC (2),
    .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(8),
    .PWRUP_CYC   (10),
    .FIFO_AW     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time LCD events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for the next lcd_en pulse and check its byte, rs and width.
  task automatic tx(input string tag, input logic exp_rs, input logic [7:0] exp_data,
                    output int rise);
    bit seen;
    int w;
    seen = 0;
    rise = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.lcd_en) seen = 1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    rise = cyc;
    check({tag, "_rs"}, 32'(bus.lcd_rs), 32'(exp_rs));
    check({tag, "_data"}, 32'(bus.lcd_data), 32'(exp_data));
    w = 0;
    while (bus.lcd_en && w < 50) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_en_width"}, 32'(w), 32'd2);
    check({tag, "_hold"}, 32'({bus.lcd_rs, bus.lcd_data}), 32'({exp_rs, exp_data}));
  endtask

  // One-cycle request pulse; n is the edge index that samples it.
  task automatic pulse(input logic c, input logic s, input logic b,
                       input logic [7:0] code, output int n);
    @(negedge clk);
    bus.char_req  = c;
    bus.space_req = s;
    bus.bksp_req  = b;
    bus.char_code = code;
    @(negedge clk);
    bus.char_req  = 1'b0;
    bus.space_req = 1'b0;
    bus.bksp_req  = 1'b0;
    n = cyc;
  endtask

  task automatic quiet(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.lcd_en) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!bus.busy) idle = 1;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  // Init sequence after reset release at edge count rel.
  task automatic do_init(input string tag, input int rel, input bit expect_idle);
    int r1, r2, r3, r4;
    tx({tag, "_38"}, 1'b0, 8'h38, r1);
    check({tag, "_first_rise"}, 32'(r1 - rel), 32'd11);
    tx({tag, "_0c"}, 1'b0, 8'h0C, r2);
    check({tag, "_gap_38"}, 32'(r2 - r1), 32'd7);
    tx({tag, "_01"}, 1'b0, 8'h01, r3);
    check({tag, "_gap_0c"}, 32'(r3 - r2), 32'd7);
    tx({tag, "_06"}, 1'b0, 8'h06, r4);
    check({tag, "_gap_clr"}, 32'(r4 - r3), 32'd11);
    if (expect_idle) begin
      // Now at r4+2; last WAIT ends at edge r4+6.
      repeat (3) @(negedge clk);
      check({tag, "_busy_in_wait"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, n, r1, r2;
    logic [7:0] code, addr;

    reset         = 1'b1;
    bus.char_req  = 1'b0;
    bus.space_req = 1'b0;
    bus.bksp_req  = 1'b0;
    bus.char_code = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.lcd_data), 32'h00);
    check("rst_rs", 32'(bus.lcd_rs), 32'd0);
    check("rst_rw", 32'(bus.lcd_rw), 32'd0);
    check("rst_en", 32'(bus.lcd_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ovf", 32'(bus.overflow), 32'd0);

    // Power-up and init
    reset = 1'b0;
    rel = cyc;
    do_init("init", rel, 1'b1);

    // 'E' from idle: address 0x80 at N+2, then data 0x45
    pulse(1'b1, 1'b0, 1'b0, 8'h45, n);
    tx("e_addr", 1'b0, 8'h80, r1);
    check("e_latency", 32'(r1 - n), 32'd2);
    tx("e_data", 1'b1, 8'h45, r2);
    check("e_gap", 32'(r2 - r1), 32'd7);
    wait_idle("e_idle");

    // Backspace from pos 1 blanks cell 0; another at pos 0 does nothing
    pulse(1'b0, 1'b0, 1'b1, 8'h00, n);
    tx("bs1_addr", 1'b0, 8'h80, r1);
    tx("bs1_data", 1'b1, 8'h20, r2);
    wait_idle("bs1_idle");
    pulse(1'b0, 1'b0, 1'b1, 8'h00, n);
    quiet("bs0_no_en", 30);
    check("bs0_busy", 32'(bus.busy), 32'd0);

    // Space request uses data 0x20, then back over it
    pulse(1'b0, 1'b1, 1'b0, 8'h00, n);
    tx("sp_addr", 1'b0, 8'h80, r1);
    tx("sp_data", 1'b1, 8'h20, r2);
    pulse(1'b0, 1'b0, 1'b1, 8'h00, n);
    tx("sp_bs_addr", 1'b0, 8'h80, r1);
    tx("sp_bs_data", 1'b1, 8'h20, r2);
    wait_idle("sp_idle");

    // 'A','B',bksp,'C' back to back from pos 0
    fork
      begin
        @(negedge clk); bus.char_req = 1'b1; bus.char_code = 8'h41;
        @(negedge clk); bus.char_code = 8'h42;
        @(negedge clk); bus.char_req = 1'b0; bus.bksp_req = 1'b1;
        @(negedge clk); bus.bksp_req = 1'b0; bus.char_req = 1'b1; bus.char_code = 8'h43;
        @(negedge clk); bus.char_req = 1'b0;
      end
      begin
        tx("a_addr", 1'b0, 8'h80, r1);
        tx("a_data", 1'b1, 8'h41, r1);
        tx("b_addr", 1'b0, 8'h81, r1);
        tx("b_data", 1'b1, 8'h42, r1);
        tx("abk_addr", 1'b0, 8'h81, r1);
        tx("abk_data", 1'b1, 8'h20, r1);
        tx("c_addr", 1'b0, 8'h81, r1);
        tx("c_data", 1'b1, 8'h43, r1);
      end
    join
    wait_idle("abc_idle");

    // Fill from pos 2 through 31 then wrap: pos 16 is 'T' at 0xC0, pos 0 at 0x80
    for (int p = 2; p <= 32; p++) begin
      code = (p == 16) ? 8'h54 : 8'h61 + 8'(p % 26);
      addr = ((p % 32) < 16) ? 8'h80 + 8'(p % 32) : 8'hC0 + 8'((p % 32) - 16);
      pulse(1'b1, 1'b0, 1'b0, code, n);
      tx($sformatf("wrap%0d_addr", p), 1'b0, addr, r1);
      tx($sformatf("wrap%0d_data", p), 1'b1, code, r2);
    end
    wait_idle("wrap_idle");

    // char_req and bksp_req together: only the backspace (pos 1 -> 0)
    pulse(1'b1, 1'b0, 1'b1, 8'h5A, n);
    tx("both_addr", 1'b0, 8'h80, r1);
    tx("both_data", 1'b1, 8'h20, r2);
    quiet("both_no_char", 30);
    check("both_busy", 32'(bus.busy), 32'd0);

    // Nine pushes during power-up: eight kept, overflow set
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ovf_before", 32'(bus.overflow), 32'd0);
      bus.char_req  = 1'b1;
      bus.char_code = 8'h30 + 8'(i);
      @(negedge clk);
    end
    bus.char_req = 1'b0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
    do_init("ovf_init", rel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tx($sformatf("ovf%0d_addr", i), 1'b0, 8'h80 + 8'(i), r1);
      tx($sformatf("ovf%0d_data", i), 1'b1, 8'h30 + 8'(i), r2);
    end
    wait_idle("ovf_idle");
    quiet("ovf_no_ninth", 20);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset while lcd_en is high
    pulse(1'b1, 1'b0, 1'b0, 8'h51, n);
    r1 = 0;
    for (int i = 0; i < 50 && r1 == 0; i++) begin
      @(negedge clk);
      if (bus.lcd_en) r1 = 1;
    end
    check("mid_en_seen", 32'(r1), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_en_drop", 32'(bus.lcd_en), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_ovf_clr", 32'(bus.overflow), 32'd0);
    check("mid_data", 32'(bus.lcd_data), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    do_init("reinit", rel, 1'b1);
    quiet("reinit_fifo_empty", 20);

    // Cursor restarted at 0
    pulse(1'b1, 1'b0, 1'b0, 8'h52, n);
    tx("r_addr", 1'b0, 8'h80, r1);
    tx("r_data", 1'b1, 8'h52, r2);
    wait_idle("r_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
